// File: rtl/shot_collider.sv
`default_nettype none
// ============================================================================
// Module      : shot_collider
// Description : Player shot launcher and enemy collision detector.
//               A fire edge in the play scene launches one shot at the player
//               X position. The shot rises on each game tick and is tested
//               against the enemy every cycle. On a hit the shot is parked,
//               o_colision is held through a cooldown window, and the score
//               increments. Enemies reaching the bottom are counted as misses.
// Ports       : clk, rst (async, active high), i_clk_en (game tick strobe),
//               i_scene, i_fire (level), i_player_x, i_ennemy_x/y, i_avoided
//               -> o_shot_x/y, o_shot_active, o_colision, o_score, o_misses
// Revision    : 1.0 - initial release
// ============================================================================
module shot_collider #(
  parameter logic [1:0] PLAY_SCENE = 2'd1,
  parameter logic [8:0] SHOT_Y0    = 9'd220,
  parameter logic [8:0] SPEED      = 9'd2,
  parameter logic [8:0] HIT_W      = 9'd12,
  parameter logic [8:0] HIT_H      = 9'd12,
  parameter logic [3:0] COOLDOWN   = 4'd8,
  parameter logic [8:0] PARK_X     = 9'd400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clk_en,
  input  logic [1:0] i_scene,
  input  logic       i_fire,
  input  logic [8:0] i_player_x,
  input  logic [8:0] i_ennemy_x,
  input  logic [8:0] i_ennemy_y,
  input  logic       i_avoided,
  output logic [8:0] o_shot_x,
  output logic [8:0] o_shot_y,
  output logic       o_shot_active,
  output logic       o_colision,
  output logic [7:0] o_score,
  output logic [7:0] o_misses
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLIGHT = 2'd1,
    S_HIT    = 2'd2
  } state_t;

  localparam logic [8:0] c_SCREEN_W = 9'd320;
  localparam logic [3:0] c_COOL_END = COOLDOWN - 4'd1;

  state_t     r_state, w_state_nx;
  logic [8:0] r_shot_x, w_shot_x_nx;
  logic [8:0] r_shot_y, w_shot_y_nx;
  logic       r_colision, w_colision_nx;
  logic [3:0] r_cool, w_cool_nx;
  logic [7:0] r_score, w_score_nx;
  logic [7:0] r_misses, w_misses_nx;
  logic       r_fire_q;
  logic [1:0] r_scene_q;

  logic              w_play, w_enter, w_fire_edge, w_hit, w_score_inc;
  logic signed [9:0] w_dx, w_dy;
  logic        [9:0] w_adx, w_ady;

  assign w_play      = (i_scene == PLAY_SCENE);
  assign w_enter     = w_play && (r_scene_q != PLAY_SCENE);
  assign w_fire_edge = i_fire & ~r_fire_q;

  // Differences are taken at 10 bits so a far-right shot against a
  // left-edge enemy cannot alias into a small distance.
  assign w_dx  = $signed({1'b0, r_shot_x}) - $signed({1'b0, i_ennemy_x});
  assign w_dy  = $signed({1'b0, r_shot_y}) - $signed({1'b0, i_ennemy_y});
  assign w_adx = w_dx[9] ? 10'(-w_dx) : 10'(w_dx);
  assign w_ady = w_dy[9] ? 10'(-w_dy) : 10'(w_dy);
  assign w_hit = (i_ennemy_x < c_SCREEN_W) &&
                 (w_adx < {1'b0, HIT_W}) && (w_ady < {1'b0, HIT_H});

  always_comb begin
    w_state_nx    = r_state;
    w_shot_x_nx   = r_shot_x;
    w_shot_y_nx   = r_shot_y;
    w_colision_nx = r_colision;
    w_cool_nx     = r_cool;
    w_score_inc   = 1'b0;

    if (!w_play) begin
      w_state_nx    = S_IDLE;
      w_shot_x_nx   = PARK_X;
      w_colision_nx = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fire_edge) begin
            w_state_nx  = S_FLIGHT;
            w_shot_x_nx = i_player_x;
            w_shot_y_nx = SHOT_Y0;
          end
        end
        S_FLIGHT: begin
          if (w_hit) begin
            w_state_nx    = S_HIT;
            w_shot_x_nx   = PARK_X;
            w_colision_nx = 1'b1;
            w_cool_nx     = 4'd0;
            w_score_inc   = 1'b1;
          end else if (i_clk_en && (r_shot_y < SPEED)) begin
            w_state_nx  = S_IDLE;
            w_shot_x_nx = PARK_X;
          end else if (i_clk_en) begin
            w_shot_y_nx = r_shot_y - SPEED;
          end
        end
        S_HIT: begin
          // Held for the whole window: the enemy only samples on non-tick cycles.
          w_colision_nx = 1'b1;
          if (i_clk_en) begin
            if (r_cool == c_COOL_END) begin
              w_state_nx    = S_IDLE;
              w_colision_nx = 1'b0;
            end else begin
              w_cool_nx = r_cool + 4'd1;
            end
          end
        end
        default: begin
          w_state_nx    = S_IDLE;
          w_shot_x_nx   = PARK_X;
          w_colision_nx = 1'b0;
        end
      endcase
    end

    // Counters restart on entry to the play scene and freeze outside it.
    w_score_nx  = r_score;
    w_misses_nx = r_misses;
    if (w_enter) begin
      w_score_nx  = 8'd0;
      w_misses_nx = 8'd0;
    end else if (w_play) begin
      if (w_score_inc && (r_score != 8'hFF)) w_score_nx = r_score + 8'd1;
      if (i_avoided && (r_misses != 8'hFF)) w_misses_nx = r_misses + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shot_x   <= PARK_X;
      r_shot_y   <= 9'd0;
      r_colision <= 1'b0;
      r_cool     <= 4'd0;
      r_score    <= 8'd0;
      r_misses   <= 8'd0;
      r_fire_q   <= 1'b0;
      r_scene_q  <= 2'd0;
    end else begin
      r_state    <= w_state_nx;
      r_shot_x   <= w_shot_x_nx;
      r_shot_y   <= w_shot_y_nx;
      r_colision <= w_colision_nx;
      r_cool     <= w_cool_nx;
      r_score    <= w_score_nx;
      r_misses   <= w_misses_nx;
      r_fire_q   <= i_fire;
      r_scene_q  <= i_scene;
    end
  end

  assign o_shot_x      = r_shot_x;
  assign o_shot_y      = r_shot_y;
  assign o_shot_active = (r_state == S_FLIGHT);
  assign o_colision    = r_colision;
  assign o_score       = r_score;
  assign o_misses      = r_misses;

endmodule
`default_nettype wire

// File: tb/tb_shot_collider.sv
`default_nettype none
// ============================================================================
// Module      : tb_shot_collider
// Description : Directed self-checking bench for shot_collider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shot_collider;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic [1:0] scene;
  logic       fire;
  logic [8:0] player_x, ennemy_x, ennemy_y;
  logic       avoided;
  logic [8:0] shot_x, shot_y;
  logic       shot_active, colision;
  logic [7:0] score, misses;

  int n_checks = 0;
  int n_errors = 0;

  shot_collider u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_clk_en     (clk_en),
    .i_scene      (scene),
    .i_fire       (fire),
    .i_player_x   (player_x),
    .i_ennemy_x   (ennemy_x),
    .i_ennemy_y   (ennemy_y),
    .i_avoided    (avoided),
    .o_shot_x     (shot_x),
    .o_shot_y     (shot_y),
    .o_shot_active(shot_active),
    .o_colision   (colision),
    .o_score      (score),
    .o_misses     (misses)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n cycles; inputs change and outputs are sampled 1ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // n game ticks, each a one-cycle strobe followed by a quiet cycle.
  task automatic tick(input int n);
    repeat (n) begin
      clk_en = 1'b1;
      step(1);
      clk_en = 1'b0;
      step(1);
    end
  endtask

  // Launch at player_x with the enemy already overlapping the launch point,
  // optionally pulsing avoided on the hit cycle, then wait out the cooldown.
  task automatic do_hit(input logic avoid);
    fire = 1'b1;
    step(1);
    fire    = 1'b0;
    avoided = avoid;
    step(1);
    avoided = 1'b0;
    tick(8);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; scene = 2'd1; fire = 1'b0;
    player_x = 9'd100; ennemy_x = 9'd400; ennemy_y = 9'd0; avoided = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_shot_x", 16'(shot_x), 16'd400);
    chk("rst_shot_y", 16'(shot_y), 16'd0);
    chk("rst_active", 16'(shot_active), 16'd0);
    chk("rst_colision", 16'(colision), 16'd0);
    chk("rst_score", 16'(score), 16'd0);
    chk("rst_misses", 16'(misses), 16'd0);
    step(1);

    // Launch does not wait for a tick.
    fire = 1'b1;
    step(1);
    chk("launch_active", 16'(shot_active), 16'd1);
    chk("launch_x", 16'(shot_x), 16'd100);
    chk("launch_y", 16'(shot_y), 16'd220);
    tick(10);
    chk("rise10_y", 16'(shot_y), 16'd200);

    // Holding fire: no relaunch, shot not reloaded.
    step(50);
    chk("hold_y", 16'(shot_y), 16'd200);
    tick(100);
    chk("top_y", 16'(shot_y), 16'd0);
    chk("top_active", 16'(shot_active), 16'd1);
    tick(1);
    chk("offtop_active", 16'(shot_active), 16'd0);
    chk("offtop_x", 16'(shot_x), 16'd400);
    chk("offtop_score", 16'(score), 16'd0);
    step(5);
    chk("hold_norelaunch", 16'(shot_active), 16'd0);
    fire = 1'b0;
    step(1);

    // Vertical approach: hit once |dy| < 12.
    ennemy_x = 9'd104; ennemy_y = 9'd190;
    fire = 1'b1;
    step(1);
    fire = 1'b0;
    tick(9);
    chk("dy12_nohit", 16'(colision), 16'd0);
    chk("dy12_y", 16'(shot_y), 16'd202);
    tick(1);
    chk("dy10_colision", 16'(colision), 16'd1);
    chk("hit_score", 16'(score), 16'd1);
    chk("hit_x", 16'(shot_x), 16'd400);
    chk("hit_active", 16'(shot_active), 16'd0);
    fire = 1'b1;  // edge during HIT must be discarded
    tick(7);
    chk("cool7_colision", 16'(colision), 16'd1);
    tick(1);
    chk("cool8_colision", 16'(colision), 16'd0);
    chk("cool8_active", 16'(shot_active), 16'd0);
    fire = 1'b0;
    step(1);

    // Off-screen enemy and 9-bit aliasing must not hit.
    player_x = 9'd505; ennemy_x = 9'd505; ennemy_y = 9'd220;
    fire = 1'b1;
    step(1);
    fire = 1'b0;
    step(2);
    chk("offscreen_nohit", 16'(colision), 16'd0);
    chk("offscreen_active", 16'(shot_active), 16'd1);
    ennemy_x = 9'd0;
    step(2);
    chk("wrap_nohit", 16'(colision), 16'd0);

    // Leaving the play scene mid-flight parks the shot and holds score.
    scene = 2'd0;
    step(1);
    chk("scene0_active", 16'(shot_active), 16'd0);
    chk("scene0_x", 16'(shot_x), 16'd400);
    chk("scene0_score", 16'(score), 16'd1);
    scene = 2'd1;
    step(1);
    chk("scene1_score", 16'(score), 16'd0);
    chk("scene1_misses", 16'(misses), 16'd0);

    // Horizontal boundary: dx=12 misses, dx=11 hits.
    player_x = 9'd100; ennemy_x = 9'd112; ennemy_y = 9'd220;
    fire = 1'b1;
    step(1);
    fire = 1'b0;
    step(2);
    chk("dx12_nohit", 16'(colision), 16'd0);
    ennemy_x = 9'd111;
    step(1);
    chk("dx11_hit", 16'(colision), 16'd1);
    chk("dx11_score", 16'(score), 16'd1);
    tick(8);

    // Hit and avoided together; then saturate score.
    ennemy_x = 9'd100;
    do_hit(1'b1);
    chk("both_score", 16'(score), 16'd2);
    chk("both_misses", 16'(misses), 16'd1);
    for (int i = 0; i < 253; i++) do_hit(1'b0);
    chk("score_255", 16'(score), 16'd255);
    do_hit(1'b0);
    chk("score_sat", 16'(score), 16'd255);
    avoided = 1'b1;
    step(1);
    avoided = 1'b0;
    chk("avoided_misses", 16'(misses), 16'd2);

    // Asynchronous reset in the middle of HIT.
    fire = 1'b1;
    step(1);
    fire = 1'b0;
    step(1);
    chk("prerst_colision", 16'(colision), 16'd1);
    rst = 1'b1;
    #1;
    chk("rst_hit_colision", 16'(colision), 16'd0);
    chk("rst_hit_x", 16'(shot_x), 16'd400);
    chk("rst_hit_score", 16'(score), 16'd0);
    step(1);
    rst = 1'b0;
    step(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
